// File: rtl/u_alu_opnd_stage.sv
// ID->EX operand stage for u_alu: operand select, EX/WB forwarding, load-use stall, one-deep buffer.
// Optional feature macro: ALU_OPND_FWD_EN (forwarding); undefined -> stall on any pending writer.
module u_alu_opnd_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_val,
  input  logic [XLEN-1:0]    id_rs2_val,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_rd_we,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_op1_pc,
  input  logic               id_op2_imm,
  input  logic [2:0]         id_f3,
  input  logic               id_f7_b5,
  input  logic               ex_fwd_we,
  input  logic               ex_fwd_ld,
  input  logic [RADDR_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]    ex_fwd_data,
  input  logic               wb_fwd_we,
  input  logic [RADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]    wb_fwd_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    alu_i1,
  output logic [XLEN-1:0]    alu_i2,
  output logic [2:0]         alu_f3,
  output logic               alu_f7_b5,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_rd_we
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_use1;
  logic               w_use2;
  logic               w_ex_hit1;
  logic               w_ex_hit2;
  logic               w_wb_hit1;
  logic               w_wb_hit2;
  logic               w_src_hazard;
  logic               w_hazard;
  logic               w_accept;
  logic               w_f7_b5;
  logic [XLEN-1:0]    w_rs1_fwd;
  logic [XLEN-1:0]    w_rs2_fwd;
  logic [XLEN-1:0]    w_op1;
  logic [XLEN-1:0]    w_op2;

  logic [XLEN-1:0]    r_alu_i1;
  logic [XLEN-1:0]    r_alu_i2;
  logic [2:0]         r_alu_f3;
  logic               r_alu_f7_b5;
  logic [XLEN-1:0]    r_ex_pc;
  logic [RADDR_W-1:0] r_ex_rd;
  logic               r_ex_rd_we;

  // Index 0 is hard-wired zero, so it never matches a producer.
  assign w_use1    = !id_op1_pc;
  assign w_use2    = !id_op2_imm;
  assign w_ex_hit1 = ex_fwd_we && (id_rs1 != '0) && (id_rs1 == ex_fwd_rd);
  assign w_ex_hit2 = ex_fwd_we && (id_rs2 != '0) && (id_rs2 == ex_fwd_rd);
  assign w_wb_hit1 = wb_fwd_we && (id_rs1 != '0) && (id_rs1 == wb_fwd_rd);
  assign w_wb_hit2 = wb_fwd_we && (id_rs2 != '0) && (id_rs2 == wb_fwd_rd);

`ifdef ALU_OPND_FWD_EN
  assign w_src_hazard = ex_fwd_ld && ((w_use1 && w_ex_hit1) || (w_use2 && w_ex_hit2));

  // The youngest producer (EX) wins over WB; a load in EX has no data yet and stalls instead.
  always_comb begin
    w_rs1_fwd = id_rs1_val;
    if (w_ex_hit1 && !ex_fwd_ld) begin
      w_rs1_fwd = ex_fwd_data;
    end else if (w_wb_hit1) begin
      w_rs1_fwd = wb_fwd_data;
    end
  end

  always_comb begin
    w_rs2_fwd = id_rs2_val;
    if (w_ex_hit2 && !ex_fwd_ld) begin
      w_rs2_fwd = ex_fwd_data;
    end else if (w_wb_hit2) begin
      w_rs2_fwd = wb_fwd_data;
    end
  end
`else
  logic w_unused_fwd;

  assign w_src_hazard = (w_use1 && (w_ex_hit1 || w_wb_hit1)) ||
                        (w_use2 && (w_ex_hit2 || w_wb_hit2));
  assign w_rs1_fwd    = id_rs1_val;
  assign w_rs2_fwd    = id_rs2_val;
  assign w_unused_fwd = ^{ex_fwd_ld, ex_fwd_data, wb_fwd_data};
`endif

  assign w_hazard = id_valid && w_src_hazard;
  assign id_ready = ((r_state == S_EMPTY) || ex_ready) && !w_hazard && !flush;
  assign w_accept = id_valid && id_ready;

  assign w_op1 = id_op1_pc  ? id_pc  : w_rs1_fwd;
  assign w_op2 = id_op2_imm ? id_imm : w_rs2_fwd;

  // Only shift-right-immediate carries funct7[5] in imm[10]; ADDI etc. must never look like SUB.
  always_comb begin
    w_f7_b5 = 1'b0;
    if (!id_op2_imm) begin
      w_f7_b5 = id_f7_b5;
    end else if (id_f3 == 3'b101) begin
      w_f7_b5 = id_imm[10];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = S_FULL;
    end else if (ex_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_comb begin
    ex_valid = (r_state == S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_i1    <= '0;
      r_alu_i2    <= '0;
      r_alu_f3    <= '0;
      r_alu_f7_b5 <= 1'b0;
      r_ex_pc     <= '0;
      r_ex_rd     <= '0;
      r_ex_rd_we  <= 1'b0;
    end else if (w_accept) begin
      r_alu_i1    <= w_op1;
      r_alu_i2    <= w_op2;
      r_alu_f3    <= id_f3;
      r_alu_f7_b5 <= w_f7_b5;
      r_ex_pc     <= id_pc;
      r_ex_rd     <= id_rd;
      r_ex_rd_we  <= id_rd_we;
    end
  end

  assign alu_i1    = r_alu_i1;
  assign alu_i2    = r_alu_i2;
  assign alu_f3    = r_alu_f3;
  assign alu_f7_b5 = r_alu_f7_b5;
  assign ex_pc     = r_ex_pc;
  assign ex_rd     = r_ex_rd;
  assign ex_rd_we  = r_ex_rd_we;

endmodule
